// File: rtl/zcursor_overlay.sv
// zcursor_overlay: draws a highlight frame around the selected menu item and a
// filled marker on the active SIN period item, in a 2-stage pixel pipeline.
// Optional feature macro: ZCURSOR_OVERLAY_BLINK_EN (blinks the frame every
// BLINK_FRAMES frames; the marker never blinks).
module zcursor_overlay #(
    parameter int          MAX_CURSOR_INDEX = 10,
    parameter int          ITEM_X0          = 16,
    parameter int          ITEM_Y0          = 16,
    parameter int          ITEM_W           = 96,
    parameter int          ITEM_H           = 18,
    parameter int          ITEM_PITCH       = 22,
    parameter int          BORDER           = 2,
    parameter int          MARKER_W         = 8,
    parameter int          PERIOD_ITEM_BASE = 1,
    parameter logic [15:0] HIGHLIGHT_COLOR  = 16'hF800,
    parameter logic [15:0] MARKER_COLOR     = 16'h07E0
`ifdef ZCURSOR_OVERLAY_BLINK_EN
    ,
    parameter int          BLINK_FRAMES     = 30
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [3:0]  iCursor_Index,
    input  logic [2:0]  iActive_Periods_Num,
    input  logic        iVSync,
    input  logic        iDE,
    input  logic [10:0] iPixel_X,
    input  logic [10:0] iPixel_Y,
    input  logic [15:0] iRGB565,
    output logic        oDE,
    output logic [15:0] oRGB565
);

    // Geometry constants, widened to 12 bits so box bottoms never wrap.
    localparam logic [11:0] X_LO    = 12'(ITEM_X0);
    localparam logic [11:0] X_HI    = 12'(ITEM_X0 + ITEM_W - 1);
    localparam logic [11:0] XB_LO   = 12'(ITEM_X0 + BORDER);
    localparam logic [11:0] XB_HI   = 12'(ITEM_X0 + ITEM_W - 1 - BORDER);
    localparam logic [11:0] MX_LO   = 12'(ITEM_X0 + BORDER + 2);
    localparam logic [11:0] MX_HI   = 12'(ITEM_X0 + BORDER + 2 + MARKER_W - 1);
    localparam logic [11:0] H_M1    = 12'(ITEM_H - 1);
    localparam logic [11:0] BRD     = 12'(BORDER);
    localparam logic [11:0] M_OFF   = 12'(BORDER + 2);
    localparam logic [11:0] MW_M1   = 12'(MARKER_W - 1);
    localparam logic [3:0]  MAX_IDX = 4'(MAX_CURSOR_INDEX);

    logic        armed_reg;     // a frame has been latched since reset / enable
    logic [3:0]  cur_idx_reg;
    logic [10:0] cy0_reg;
    logic [10:0] my0_reg;
    logic        blink_vis;

    logic        de1_reg;
    logic [15:0] rgb1_reg;
    logic        border1_reg;
    logic        marker1_reg;

    logic [11:0] x12, y12, cy12, my12;
    logic        in_box, on_border, in_marker, active;

    // Per-frame latch of cursor and marker geometry, taken only on iVSync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_reg   <= 1'b0;
            cur_idx_reg <= '0;
            cy0_reg     <= '0;
            my0_reg     <= '0;
        end else if (!en) begin
            armed_reg   <= 1'b0;
            cur_idx_reg <= '0;
            cy0_reg     <= '0;
            my0_reg     <= '0;
        end else if (iVSync) begin
            armed_reg   <= 1'b1;
            cur_idx_reg <= iCursor_Index;
            cy0_reg     <= 11'(ITEM_Y0) + 11'(iCursor_Index) * 11'(ITEM_PITCH);
            my0_reg     <= 11'(ITEM_Y0)
                         + 11'(4'(PERIOD_ITEM_BASE) + {1'b0, iActive_Periods_Num})
                         * 11'(ITEM_PITCH);
        end
    end

`ifdef ZCURSOR_OVERLAY_BLINK_EN
    localparam int CW = $clog2(BLINK_FRAMES);
    logic [CW-1:0] blink_cnt_reg;
    logic          blink_vis_reg;

    // Frame counter: restarts visible on a new cursor, toggles phase on wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_reg <= '0;
            blink_vis_reg <= 1'b1;
        end else if (!en) begin
            blink_cnt_reg <= '0;
            blink_vis_reg <= 1'b1;
        end else if (iVSync) begin
            if (!armed_reg || (iCursor_Index != cur_idx_reg)) begin
                blink_cnt_reg <= '0;
                blink_vis_reg <= 1'b1;
            end else if (blink_cnt_reg == CW'(BLINK_FRAMES - 1)) begin
                blink_cnt_reg <= '0;
                blink_vis_reg <= ~blink_vis_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + 1'b1;
            end
        end
    end
    assign blink_vis = blink_vis_reg;
`else
    assign blink_vis = 1'b1;
`endif

    // Box / border / marker hit tests against the latched geometry.
    always_comb begin
        x12       = {1'b0, iPixel_X};
        y12       = {1'b0, iPixel_Y};
        cy12      = {1'b0, cy0_reg};
        my12      = {1'b0, my0_reg};
        active    = en && armed_reg;
        in_box    = (x12 >= X_LO) && (x12 <= X_HI) &&
                    (y12 >= cy12) && (y12 <= cy12 + H_M1);
        on_border = in_box && ((x12 < XB_LO) || (x12 > XB_HI) ||
                               (y12 < cy12 + BRD) || (y12 > cy12 + H_M1 - BRD));
        in_marker = (x12 >= MX_LO) && (x12 <= MX_HI) &&
                    (y12 >= my12 + M_OFF) && (y12 <= my12 + M_OFF + MW_M1);
    end

    // Stage 1: register pixel and hit conditions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de1_reg     <= 1'b0;
            rgb1_reg    <= '0;
            border1_reg <= 1'b0;
            marker1_reg <= 1'b0;
        end else begin
            de1_reg     <= iDE;
            rgb1_reg    <= iRGB565;
            border1_reg <= active && on_border;
            marker1_reg <= active && in_marker;
        end
    end

    // Stage 2: priority mux frame > marker > upstream; blank when not valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oDE     <= 1'b0;
            oRGB565 <= '0;
        end else begin
            oDE <= de1_reg;
            if (!de1_reg)
                oRGB565 <= '0;
            else if (border1_reg && (cur_idx_reg <= MAX_IDX) && blink_vis)
                oRGB565 <= HIGHLIGHT_COLOR;
            else if (marker1_reg)
                oRGB565 <= MARKER_COLOR;
            else
                oRGB565 <= rgb1_reg;
        end
    end

endmodule

// File: tb/tb_zcursor_overlay.sv
// Directed self-checking bench for zcursor_overlay.
module tb_zcursor_overlay;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  iCursor_Index = '0;
    logic [2:0]  iActive_Periods_Num = '0;
    logic        iVSync = 1'b0;
    logic        iDE = 1'b0;
    logic [10:0] iPixel_X = '0;
    logic [10:0] iPixel_Y = '0;
    logic [15:0] iRGB565 = '0;
    logic        oDE;
    logic [15:0] oRGB565;

    int errors = 0;
    int checks = 0;

    localparam logic [15:0] HI = 16'hF800;
    localparam logic [15:0] MK = 16'h07E0;

    zcursor_overlay dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .iCursor_Index(iCursor_Index), .iActive_Periods_Num(iActive_Periods_Num),
        .iVSync(iVSync), .iDE(iDE), .iPixel_X(iPixel_X), .iPixel_Y(iPixel_Y),
        .iRGB565(iRGB565), .oDE(oDE), .oRGB565(oRGB565)
    );

    always #5 clk = ~clk;

    task automatic vsync();
        @(negedge clk);
        iVSync = 1'b1;
        @(negedge clk);
        iVSync = 1'b0;
    endtask

    // One isolated pixel; checked two clock edges after it is presented.
    task automatic pix(input string name, input int x, input int y,
                       input logic [15:0] rgb, input logic [15:0] exp);
        @(negedge clk);
        iDE = 1'b1; iPixel_X = 11'(x); iPixel_Y = 11'(y); iRGB565 = rgb;
        @(posedge clk);
        @(negedge clk);
        iDE = 1'b0; iRGB565 = 16'h0;
        @(posedge clk);
        #1;
        checks++;
        if (oDE !== 1'b1 || oRGB565 !== exp) begin
            errors++;
            $display("FAIL %s (%0d,%0d): got oDE=%b rgb=%h expected oDE=1 rgb=%h",
                     name, x, y, oDE, oRGB565, exp);
        end else
            $display("ok   %s (%0d,%0d): rgb=%h", name, x, y, oRGB565);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; iCursor_Index = 4'd0;
        @(negedge clk);
        iDE = 1'b1; iRGB565 = 16'hBEEF;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (oDE !== 1'b0 || oRGB565 !== 16'h0) begin
            errors++;
            $display("FAIL reset_hold: got oDE=%b rgb=%h expected 0/0000", oDE, oRGB565);
        end else
            $display("ok   reset_hold");
        iDE = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vsync();
        pix("basic_pass", 300, 200, 16'h1234, 16'h1234);
        @(posedge clk); #1;
        checks++;
        if (oDE !== 1'b0 || oRGB565 !== 16'h0) begin
            errors++;
            $display("FAIL idle_blank: got oDE=%b rgb=%h expected 0/0000", oDE, oRGB565);
        end else
            $display("ok   idle_blank");
    endtask

    task automatic test_frame();
        iCursor_Index = 4'd3; iActive_Periods_Num = 3'd0;
        vsync();
        pix("frame_tl", 16, 82, 16'h1111, HI);
        pix("frame_br", 111, 99, 16'h2222, HI);
        pix("frame_inner", 50, 90, 16'h3333, 16'h3333);
        pix("frame_right_out", 112, 82, 16'h4444, 16'h4444);
    endtask

    task automatic test_midframe();
        iCursor_Index = 4'd4;
        pix("mid_new_item", 16, 104, 16'h5555, 16'h5555);
        pix("mid_old_item", 16, 82, 16'h5656, HI);
        vsync();
        pix("next_new_item", 16, 104, 16'h6666, HI);
        pix("next_old_item", 16, 82, 16'h7777, 16'h7777);
    endtask

    task automatic test_marker();
        iCursor_Index = 4'd3; iActive_Periods_Num = 3'd2;
        vsync();
        pix("marker_tl", 20, 86, 16'h0101, MK);
        pix("marker_br", 27, 93, 16'h0202, MK);
        pix("marker_right_out", 28, 86, 16'h0303, 16'h0303);
        pix("marker_frame_prio", 16, 82, 16'h0404, HI);
    endtask

    task automatic test_back_to_back();
        int xs[5] = '{15, 16, 17, 18, 111};
        logic [15:0] ex[5];
        ex[0] = 16'hA000; ex[1] = HI; ex[2] = HI; ex[3] = 16'hA003; ex[4] = HI;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i < 5) begin
                iDE = 1'b1; iPixel_X = 11'(xs[i]); iPixel_Y = 11'd90;
                iRGB565 = 16'hA000 + 16'(i);
            end else
                iDE = 1'b0;
            @(posedge clk); #1;
            if (i >= 1) begin
                checks++;
                if (oDE !== 1'b1 || oRGB565 !== ex[i-1]) begin
                    errors++;
                    $display("FAIL b2b[%0d]: got oDE=%b rgb=%h expected 1/%h",
                             i - 1, oDE, oRGB565, ex[i-1]);
                end else
                    $display("ok   b2b[%0d]: rgb=%h", i - 1, oRGB565);
            end
        end
    endtask

    task automatic test_out_of_range();
        iCursor_Index = 4'd12; iActive_Periods_Num = 3'd2;
        vsync();
        for (int i = 0; i <= 12; i += 3)
            pix("oor_no_frame", 16, 16 + i * 22, 16'h0F00 + 16'(i), 16'h0F00 + 16'(i));
        pix("oor_marker", 20, 86, 16'h0F0F, MK);
    endtask

    task automatic test_disable();
        iCursor_Index = 4'd3; iActive_Periods_Num = 3'd2;
        vsync();
        @(negedge clk);
        en = 1'b0;
        pix("dis_frame", 16, 82, 16'hC001, 16'hC001);
        pix("dis_marker", 20, 86, 16'hC002, 16'hC002);
        @(negedge clk);
        en = 1'b1;
        pix("en_before_vs", 16, 82, 16'hC003, 16'hC003);
        vsync();
        pix("en_after_vs", 16, 82, 16'hC004, HI);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        iDE = 1'b1; iPixel_X = 11'd300; iPixel_Y = 11'd200; iRGB565 = 16'h9999;
        @(posedge clk); @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (oDE !== 1'b0 || oRGB565 !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: got oDE=%b rgb=%h expected 0/0000", oDE, oRGB565);
        end else
            $display("ok   async_reset");
        iDE = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        pix("post_reset_no_frame", 16, 82, 16'hD001, 16'hD001);
        vsync();
        pix("post_reset_vs", 16, 82, 16'hD002, HI);
    endtask

`ifdef ZCURSOR_OVERLAY_BLINK_EN
    task automatic test_blink();
        do_reset();
        iCursor_Index = 4'd3; iActive_Periods_Num = 3'd0;
        vsync();
        for (int k = 0; k <= 34; k++) begin
            pix("blink", 16, 82, 16'h00AA, (k < 30) ? HI : 16'h00AA);
            if (k < 34) vsync();
        end
        iCursor_Index = 4'd5;
        vsync();
        pix("blink_new_item", 16, 126, 16'h00BB, HI);
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_midframe();
        test_marker();
        test_back_to_back();
        test_out_of_range();
        test_disable();
        test_async_reset();
`ifdef ZCURSOR_OVERLAY_BLINK_EN
        test_blink();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
